music_player_ng: RTL and testbench

MUSIC_PLAYER_NG -- requirements
Module: music_player_ng

---
 rtl/music_player_ng.sv | 126 ++++++++++++
 tb/tb_music_player_ng.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/music_player_ng.sv
// music_player_ng: ROM-driven square-wave note sequencer with play/pause, song select and repeat.
module music_player_ng #(
    parameter int SIM = 0,
    parameter int SONGS = 4,
    parameter int SAMPLE_W = 16,
    parameter int NOTE_AW = 5,
    parameter int BEAT_FRAMES = 12000,
    localparam int SB = $clog2(SONGS),
    localparam int PHASE_W = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        play_pause,
    input  logic                        next,
    input  logic                        prev,
    input  logic                        repeat_mode,
    input  logic                        NewFrame,
    input  logic [15:0]                 rom_data,
    output logic [SB+NOTE_AW-1:0]       rom_addr,
    output logic signed [SAMPLE_W-1:0]  sample,
    output logic                        play,
    output logic [SB-1:0]               song
);
    localparam int BL = SIM ? 4 : BEAT_FRAMES;
    localparam int FW = $clog2(BL + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BL - 1);
    localparam logic [SB-1:0] LAST_SONG = SB'(SONGS - 1);
    localparam logic [SAMPLE_W-1:0] POS = SAMPLE_W'(2 ** (SAMPLE_W - 2));
    localparam logic [SAMPLE_W-1:0] NEG = SAMPLE_W'(-(2 ** (SAMPLE_W - 2)));

    typedef enum logic [1:0] {PAUSE, FETCH, LOAD, PLAY} state_t;

    state_t state, state_n;
    logic play_n, eos;
    logic [SB-1:0] song_n;
    logic [NOTE_AW-1:0] idx, idx_n;
    logic [FW-1:0] frame, frame_n;
    logic [5:0] beat, beat_n, dur, dur_n;
    logic [9:0] step, step_n;
    logic [PHASE_W-1:0] phase, phase_n;
    logic [SAMPLE_W-1:0] smp, smp_n;

    assign rom_addr = {song, idx};
    assign sample = (play && state == PLAY) ? smp : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAUSE;
            play  <= 1'b0;
            song  <= '0;
            idx   <= '0;
            frame <= '0;
            beat  <= '0;
            dur   <= '0;
            step  <= '0;
            phase <= '0;
            smp   <= '0;
        end else begin
            state <= state_n;
            play  <= play_n;
            song  <= song_n;
            idx   <= idx_n;
            frame <= frame_n;
            beat  <= beat_n;
            dur   <= dur_n;
            step  <= step_n;
            phase <= phase_n;
            smp   <= smp_n;
        end
    end

    always_comb begin
        state_n = state;
        play_n  = play ^ play_pause;
        song_n  = song;
        idx_n   = idx;
        frame_n = frame;
        beat_n  = beat;
        dur_n   = dur;
        step_n  = step;
        phase_n = phase;
        smp_n   = smp;
        eos     = 1'b0;
        case (state)
            PAUSE: state_n = play_n ? FETCH : PAUSE;
            FETCH: state_n = LOAD;
            LOAD: begin
                step_n  = rom_data[15:6];
                dur_n   = rom_data[5:0];
                phase_n = '0;
                frame_n = '0;
                beat_n  = '0;
                eos     = (rom_data[5:0] == 6'd0);
                state_n = PLAY;
            end
            PLAY: if (play && NewFrame) begin
                phase_n = phase + PHASE_W'(step);
                smp_n   = (step == 10'd0) ? '0 : phase_n[PHASE_W-1] ? NEG : POS;
                frame_n = (frame == LAST_FRAME) ? '0 : frame + 1'b1;
                beat_n  = (frame == LAST_FRAME) ? beat + 1'b1 : beat;
                if (frame == LAST_FRAME && beat_n == dur) begin
                    beat_n  = '0;
                    idx_n   = idx + 1'b1;
                    eos     = &idx;
                    state_n = FETCH;
                end
            end
            default: state_n = PAUSE;
        endcase
        // End of song: either replay this song or advance to the next one
        if (eos) begin
            idx_n   = '0;
            state_n = FETCH;
            song_n  = repeat_mode ? song : (song == LAST_SONG) ? '0 : song + 1'b1;
        end
        if (next ^ prev) begin
            song_n  = next ? ((song == LAST_SONG) ? '0 : song + 1'b1)
                           : ((song == '0) ? LAST_SONG : song - 1'b1);
            idx_n   = '0;
            frame_n = '0;
            beat_n  = '0;
            phase_n = '0;
            state_n = FETCH;
        end
    end
endmodule

// File: tb/tb_music_player_ng.sv
// tb_music_player_ng: directed bench with a note-level reference model for two beat lengths.
module tb_music_player_ng;
    logic clk, reset, play_pause, next, prev, repeat_mode, NewFrame;
    logic [15:0] rd1, rd2;
    logic [3:0] a1, a2;
    logic signed [15:0] s1, s2;
    logic p1, p2;
    logic [1:0] g1, g2;
    logic [15:0] rom [16];

    int total = 0, bad = 0;
    bit chk_on = 0;

    music_player_ng #(.SIM(1), .SONGS(4), .SAMPLE_W(16), .NOTE_AW(2), .BEAT_FRAMES(12000)) dut1 (
        .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
        .repeat_mode(repeat_mode), .NewFrame(NewFrame), .rom_data(rd1), .rom_addr(a1),
        .sample(s1), .play(p1), .song(g1));
    music_player_ng #(.SIM(0), .SONGS(4), .SAMPLE_W(16), .NOTE_AW(2), .BEAT_FRAMES(16)) dut2 (
        .clk(clk), .reset(reset), .play_pause(play_pause), .next(next), .prev(prev),
        .repeat_mode(repeat_mode), .NewFrame(NewFrame), .rom_data(rd2), .rom_addr(a2),
        .sample(s2), .play(p2), .song(g2));

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd1 <= rom[a1];
        rd2 <= rom[a2];
    end

    // Reference model: tracks frames remaining in the current note and the fetch gap
    int bl [2] = '{4, 16};
    int m_song [2], m_idx [2], m_gap [2], m_left [2], m_step [2], m_phase [2], m_smp [2];
    bit m_play [2], m_idle [2];
    bit np, sw;
    logic [15:0] w;

    function automatic void end_song(input int k);
        m_idx[k] = 0;
        m_gap[k] = 2;
        if (!repeat_mode) m_song[k] = (m_song[k] + 1) % 4;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            chk_on = 1;
            for (int k = 0; k < 2; k++) begin
                m_song[k] = 0; m_idx[k] = 0; m_gap[k] = 0; m_left[k] = 0;
                m_step[k] = 0; m_phase[k] = 0; m_smp[k] = 0; m_play[k] = 0; m_idle[k] = 1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                np = m_play[k] ^ play_pause;
                sw = next ^ prev;
                if (m_idle[k]) begin
                    if (np) begin m_idle[k] = 0; m_gap[k] = 2; end
                end else if (m_gap[k] == 2) m_gap[k] = 1;
                else if (m_gap[k] == 1) begin
                    w = rom[m_song[k] * 4 + m_idx[k]];
                    if (w[5:0] == 0) end_song(k);
                    else begin
                        m_left[k] = int'(w[5:0]) * bl[k];
                        m_step[k] = int'(w[15:6]);
                        m_phase[k] = 0;
                        m_gap[k] = 0;
                    end
                end else if (m_play[k] && NewFrame) begin
                    m_phase[k] = (m_phase[k] + m_step[k]) % (1 << 20);
                    m_smp[k] = (m_step[k] == 0) ? 0 : (m_phase[k] >= (1 << 19)) ? -16384 : 16384;
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        if (m_idx[k] == 3) end_song(k);
                        else begin m_idx[k]++; m_gap[k] = 2; end
                    end
                end
                if (sw) begin
                    m_song[k] = next ? (m_song[k] + 1) % 4 : (m_song[k] + 3) % 4;
                    m_idx[k] = 0;
                    m_gap[k] = 2;
                    m_idle[k] = 0;
                end
                m_play[k] = np;
            end
        end
    end

    task automatic cmp(input int k, input int a, input int p, input int g, input int s);
        int ea = m_song[k] * 4 + m_idx[k];
        int es = (m_play[k] && !m_idle[k] && m_gap[k] == 0) ? m_smp[k] : 0;
        total++;
        if (a != ea || p != int'(m_play[k]) || g != m_song[k] || s != es) begin
            bad++;
            $display("FAIL model_dut%0d t=%0t addr/play/song/sample got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     k + 1, $time, a, p, g, s, ea, m_play[k], m_song[k], es);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        cmp(0, a1, p1, g1, s1);
        cmp(1, a2, p2, g2, s2);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int which);
        if (which == 0) play_pause = 1;
        if (which == 1 || which == 3) next = 1;
        if (which == 2 || which == 3) prev = 1;
        @(negedge clk);
        play_pause = 0; next = 0; prev = 0;
    endtask

    task automatic frame();
        NewFrame = 1;
        @(negedge clk);
        NewFrame = 0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] note(input int st, input int d);
        return {st[9:0], d[5:0]};
    endfunction

    int n;
    bit seen_neg;

    initial begin
        rom[0]  = note(16'h100, 2);  rom[1]  = note(16'h040, 4);
        rom[2]  = note(0, 1);        rom[3]  = note(16'h3FF, 63);
        rom[4]  = note(16'h010, 1);  rom[5]  = note(16'h020, 1);
        rom[6]  = note(16'h030, 1);  rom[7]  = note(0, 0);
        rom[8]  = note(16'h005, 1);  rom[9]  = note(16'h006, 1);
        rom[10] = note(16'h007, 1);  rom[11] = note(16'h008, 1);
        rom[12] = note(16'h3FF, 63); rom[13] = note(16'h001, 2);
        rom[14] = note(0, 0);        rom[15] = note(16'h002, 1);
        reset = 1; play_pause = 0; next = 0; prev = 0; repeat_mode = 0; NewFrame = 0;
        cyc(2);
        chk("reset_addr", a1, 0);
        chk("reset_play", p1, 0);
        chk("reset_song", g1, 0);
        chk("reset_sample", s1, 0);
        reset = 0;
        cyc(1);
        // First note: 2 beats x 4 frames, then advance to address 1
        pulse(0);
        chk("start_play", p1, 1);
        chk("start_addr", a1, 0);
        cyc(2);
        frame();
        chk("first_sample", s1, 16384);
        n = 1;
        while (a1 != 1 && n < 50) begin frame(); n++; end
        chk("note0_frames", n, 8);
        cyc(1);
        // Pause mid-note for 10 frames, then resume
        repeat (5) frame();
        pulse(0);
        chk("paused_play", p1, 0);
        repeat (10) frame();
        chk("paused_sample", s1, 0);
        chk("paused_addr", a1, 1);
        pulse(0);
        n = 0;
        while (a1 != 2 && n < 40) begin frame(); n++; end
        chk("resume_frames", n, 11);
        // Song select wrap-around and simultaneous next/prev
        repeat (3) pulse(1);
        chk("next_to_3", g1, 3);
        pulse(1);
        chk("next_wrap", g1, 0);
        pulse(2);
        chk("prev_wrap", g1, 3);
        pulse(3);
        chk("next_prev_ignored", g1, 3);
        repeat (2) pulse(2);
        chk("back_to_1", g1, 1);
        // Zero-duration note ends the song
        n = 0;
        while (g1 == 1 && n < 60) begin frame(); n++; end
        chk("eos_song", g1, 2);
        chk("eos_addr", a1, 8);
        repeat_mode = 1;
        pulse(2);
        n = 0;
        while (a1 != 7 && n < 60) begin frame(); n++; end
        n = 0;
        while (a1 == 7 && n < 6) begin cyc(1); n++; end
        chk("repeat_addr", a1, 4);
        chk("repeat_song", g1, 1);
        // Reset in the middle of a playing note with a frame pulse present
        cyc(3);
        reset = 1; NewFrame = 1;
        @(negedge clk);
        chk("midreset_addr", a1, 0);
        chk("midreset_play", p1, 0);
        chk("midreset_song", g1, 0);
        chk("midreset_sample", s1, 0);
        chk("midreset_sample2", s2, 0);
        reset = 0; NewFrame = 0; repeat_mode = 0;
        cyc(1);
        // Long note on the slower instance reaches the negative half of the phase
        repeat (3) pulse(1);
        pulse(0);
        seen_neg = 0;
        repeat (1100) begin
            frame();
            if (s2 == -16384) seen_neg = 1;
        end
        chk("negative_half", int'(seen_neg), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
